physical_test_sequencer: RTL and testbench

//  Parametrised on-board instruction sequencer for FPGA processor bring-up.

---
 rtl/physical_test_sequencer_pkg.sv | 22 ++
 rtl/physical_test_sequencer_if.sv | 20 ++
 rtl/test_prog_ram.sv | 24 ++
 rtl/physical_test_sequencer.sv | 172 +++++++++++++++++
 tb/tb_physical_test_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/physical_test_sequencer_pkg.sv
// Shared types for the bring-up instruction sequencer: FSM states, run modes and
// the width of the saturating mismatch counter.
package physical_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_STEP  = 2'b00,
    MODE_PACED = 2'b01,
    MODE_FAST  = 2'b10,
    MODE_LOOP  = 2'b11
  } mode_t;

  localparam int ERR_W = 8;

endpackage

// File: rtl/physical_test_sequencer_if.sv
// Instruction/result link between the sequencer (master) and the processor under test (slave).
interface physical_test_sequencer_if #(
  parameter int INSTR_WIDTH = 16
);
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   result_valid;
  logic [INSTR_WIDTH-1:0] result_in;

  modport master (
    output instruction, instr_valid,
    input  instr_ready, result_valid, result_in
  );

  modport slave (
    input  instruction, instr_valid,
    output instr_ready, result_valid, result_in
  );
endinterface

// File: rtl/test_prog_ram.sv
// Test program store: one write port, one synchronous read port with 1-cycle latency.
// Contents are never reset so a program survives a sequencer reset.
module test_prog_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/physical_test_sequencer.sv
// On-board instruction sequencer: issues a stored test program to a processor in
// step / paced / fast / loop modes and counts result mismatches.
module physical_test_sequencer
  import physical_test_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int STEP_DIV    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic [1:0]             mode,
  input  logic [ADDR_WIDTH-1:0]  end_addr,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [INSTR_WIDTH-1:0] load_expect,
  physical_test_sequencer_if.master proc,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_W-1:0]       err_count,
  output logic [ADDR_WIDTH-1:0]  first_fail
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] PACE_LAST = CNT_W'(STEP_DIV - 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t                   state, state_next;
  mode_t                    mode_q;
  logic [ADDR_WIDTH-1:0]    pc_q, end_q, first_fail_q;
  logic [CNT_W-1:0]         pace_cnt;
  logic [ERR_W-1:0]         err_q;
  logic                     start_q, step_q, stop_pend, hs_seen;
  logic                     start_rise, step_rise, handshake;
  logic                     do_start, do_adv, do_wrap;
  logic [2*INSTR_WIDTH-1:0] rd_data_p1;
  logic [INSTR_WIDTH-1:0]   expect_p2;
  logic [ADDR_WIDTH-1:0]    expect_addr_p2;

  assign start_rise = start & ~start_q;
  assign step_rise  = step & ~step_q;
  assign handshake  = (state == ST_ISSUE) && proc.instr_ready;

  test_prog_ram #(
    .WIDTH      (2*INSTR_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (load_en && !busy),
    .wr_addr (load_addr),
    .wr_data ({load_expect, load_instr}),
    .rd_en   (state == ST_FETCH),
    .rd_addr (pc_q),
    .rd_data (rd_data_p1)
  );

  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_adv     = 1'b0;
    do_wrap    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          do_start   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = stop ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        // A pending stop never cuts a presented instruction short.
        if (handshake) state_next = (stop || stop_pend) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (stop) begin
          state_next = ST_DONE;
        end else if (pc_q == end_q) begin
          if (mode_q == MODE_LOOP) begin
            do_wrap    = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          case (mode_q)
            MODE_STEP:  do_adv = step_rise;
            MODE_PACED: do_adv = (pace_cnt == PACE_LAST);
            default:    do_adv = 1'b1;
          endcase
          if (do_adv) state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_STEP;
      pc_q         <= '0;
      end_q        <= '0;
      pace_cnt     <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      start_q      <= 1'b0;
      step_q       <= 1'b0;
      stop_pend    <= 1'b0;
      hs_seen      <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start;
      step_q  <= step;

      if (do_start) begin
        pc_q      <= '0;
        end_q     <= end_addr;
        stop_pend <= 1'b0;
        hs_seen   <= 1'b0;
      end else if (do_wrap) begin
        pc_q <= '0;
      end else if (do_adv) begin
        pc_q <= pc_q + 1'b1;
      end

      if (state == ST_ISSUE && stop) stop_pend <= 1'b1;

      // Mode is sampled at acceptance so a switch mid-run applies from the next WAIT.
      if (handshake) begin
        mode_q  <= mode_t'(mode);
        hs_seen <= 1'b1;
      end

      pace_cnt <= (state == ST_WAIT) ? pace_cnt + 1'b1 : '0;

      if (do_start) begin
        err_q        <= '0;
        first_fail_q <= '0;
      end else if (proc.result_valid && hs_seen && (proc.result_in != expect_p2)) begin
        err_q <= sat_inc(err_q);
        if (err_q == '0) first_fail_q <= expect_addr_p2;
      end
    end
  end

  // ---- checker capture: expected word and address of the accepted entry ----
  always_ff @(posedge clock) begin
    if (handshake) begin
      expect_p2      <= rd_data_p1[2*INSTR_WIDTH-1:INSTR_WIDTH];
      expect_addr_p2 <= pc_q;
    end
  end

  assign proc.instr_valid = (state == ST_ISSUE);
  assign proc.instruction = (state == ST_ISSUE) ? rd_data_p1[INSTR_WIDTH-1:0] : '0;
  assign pc         = pc_q;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign err_count  = err_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_physical_test_sequencer.sv
// Directed bench for physical_test_sequencer: run modes, pacing, stall/stop, checker, loop and reset.
module tb_physical_test_sequencer;

  localparam int IW = 16;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [1:0]    mode = 2'b10;
  logic [AW-1:0] end_addr = '0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_instr = '0, load_expect = '0;
  logic [AW-1:0] pc, first_fail;
  logic          busy, done;
  logic [7:0]    err_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [IW-1:0] hs_instr[$];
  int            hs_cyc[$];
  int            hs_pc[$];

  physical_test_sequencer_if #(.INSTR_WIDTH(IW)) u_if ();

  physical_test_sequencer #(
    .INSTR_WIDTH(IW), .DEPTH(32), .ADDR_WIDTH(AW), .STEP_DIV(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .step(step),
    .mode(mode), .end_addr(end_addr), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_expect(load_expect), .proc(u_if.master),
    .pc(pc), .busy(busy), .done(done), .err_count(err_count), .first_fail(first_fail)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every accepted instruction, sampled mid-cycle.
  always @(negedge clock) begin
    if (u_if.instr_valid && u_if.instr_ready) begin
      hs_instr.push_back(u_if.instruction);
      hs_cyc.push_back(cyc);
      hs_pc.push_back(int'(pc));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] ins, input logic [IW-1:0] ex);
    load_en = 1'b1; load_addr = a; load_instr = ins; load_expect = ex;
    tick();
    load_en = 1'b0;
  endtask

  task automatic clear_log();
    hs_instr.delete(); hs_cyc.delete(); hs_pc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_hs(input int n, input string tag);
    int k = 0;
    while (hs_instr.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(hs_instr.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, 32'(u_if.instruction), 32'd0);
    check({tag, "_valid"}, 32'(u_if.instr_valid), 32'd0);
    check({tag, "_pc"},    32'(pc), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err_count), 32'd0);
    check({tag, "_ff"},    32'(first_fail), 32'd0);
  endtask

  task automatic press_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick(4);
  endtask

  initial begin
    u_if.instr_ready  = 1'b1;
    u_if.result_valid = 1'b0;
    u_if.result_in    = '0;

    tick(2);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    load(5'd0, 16'h1001, 16'h0000);
    load(5'd1, 16'h1002, 16'h00AA);
    load(5'd2, 16'h1003, 16'h0002);
    load(5'd3, 16'h1004, 16'h0033);

    // Fast run: 2-cycle issue latency, 4 handshakes 3 cycles apart.
    mode = 2'b10; end_addr = 5'd3; clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fast_lat1_valid", 32'(u_if.instr_valid), 32'd0);
    check("fast_lat1_busy", 32'(busy), 32'd1);
    tick();
    check("fast_lat2_valid", 32'(u_if.instr_valid), 32'd1);
    check("fast_lat2_instr", 32'(u_if.instruction), 32'h1001);
    wait_done("fast_done");
    check("fast_busy", 32'(busy), 32'd0);
    check("fast_count", 32'(hs_instr.size()), 32'd4);
    for (int i = 0; i < 4 && i < hs_instr.size(); i++)
      check($sformatf("fast_instr%0d", i), 32'(hs_instr[i]), 32'h1001 + 32'(i));
    if (hs_cyc.size() >= 4)
      check("fast_spacing", 32'(hs_cyc[3] - hs_cyc[0]), 32'd9);

    // Step mode, with a result strobe before any acceptance that must be ignored.
    mode = 2'b00; clear_log();
    pulse_start();
    u_if.result_valid = 1'b1; u_if.result_in = 16'hDEAD;
    tick();
    u_if.result_valid = 1'b0;
    wait_hs(1, "step_hs0");
    tick(10);
    check("step_hold_count", 32'(hs_instr.size()), 32'd1);
    check("step_hold_pc", 32'(pc), 32'd0);
    check("step_hold_valid", 32'(u_if.instr_valid), 32'd0);
    u_if.result_valid = 1'b1; u_if.result_in = 16'h0000;
    tick();
    u_if.result_valid = 1'b0;
    tick();
    check("chk_early_ignored", 32'(err_count), 32'd0);

    press_step();
    check("step1_count", 32'(hs_instr.size()), 32'd2);
    u_if.result_valid = 1'b1; u_if.result_in = 16'h00AB;
    tick();
    u_if.result_valid = 1'b0;
    tick();
    check("chk_err1", 32'(err_count), 32'd1);
    check("chk_ff1", 32'(first_fail), 32'd1);

    press_step();
    u_if.result_valid = 1'b1; u_if.result_in = 16'h0002;
    tick();
    u_if.result_valid = 1'b0;
    tick();
    check("chk_match2", 32'(err_count), 32'd1);

    press_step();
    u_if.result_valid = 1'b1; u_if.result_in = 16'h0000;
    tick();
    u_if.result_valid = 1'b0;
    tick();
    check("chk_err2", 32'(err_count), 32'd2);
    check("chk_ff_kept", 32'(first_fail), 32'd1);
    check("step_done", 32'(done), 32'd1);
    check("step_count", 32'(hs_instr.size()), 32'd4);
    if (hs_instr.size() >= 4)
      check("step_last", 32'(hs_instr[3]), 32'h1004);

    // Paced run: STEP_DIV=4 gives 6 cycles between acceptances.
    mode = 2'b01; clear_log();
    pulse_start();
    check("restart_err_clr", 32'(err_count), 32'd0);
    wait_done("paced_done");
    check("paced_count", 32'(hs_instr.size()), 32'd4);
    for (int i = 0; i + 1 < hs_cyc.size(); i++)
      check($sformatf("paced_gap%0d", i), 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd6);
    for (int i = 0; i < hs_pc.size(); i++)
      check($sformatf("paced_pc%0d", i), 32'(hs_pc[i]), 32'(i));

    // Stall in ISSUE for 5 cycles; stop raised there ends the run after acceptance.
    mode = 2'b10; u_if.instr_ready = 1'b0; clear_log();
    pulse_start();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_valid%0d", i), 32'(u_if.instr_valid), 32'd1);
      check($sformatf("stall_instr%0d", i), 32'(u_if.instruction), 32'h1001);
      if (i == 1) stop = 1'b1;
      tick();
    end
    u_if.instr_ready = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_done", 32'(done), 32'd1);
    check("stop_valid", 32'(u_if.instr_valid), 32'd0);
    check("stop_count", 32'(hs_instr.size()), 32'd1);

    // Loop mode end_addr=1, write attempt while busy, then reset mid-ISSUE.
    mode = 2'b11; end_addr = 5'd1; clear_log();
    pulse_start();
    load(5'd0, 16'hBEEF, 16'hBEEF);
    wait_hs(4, "loop_hs4");
    for (int i = 0; i < 4 && i < hs_instr.size(); i++)
      check($sformatf("loop_instr%0d", i), 32'(hs_instr[i]), (i % 2 == 0) ? 32'h1001 : 32'h1002);
    u_if.result_valid = 1'b1; u_if.result_in = 16'hFFFF;
    tick();
    u_if.result_valid = 1'b0;
    tick();
    check("loop_err", 32'(err_count), 32'd1);
    begin
      int k = 0;
      while (!u_if.instr_valid && k < 20) begin
        tick();
        k++;
      end
    end
    check("loop_in_issue", 32'(u_if.instr_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    tick();

    // Restart reissues the original program.
    mode = 2'b10; end_addr = 5'd3; clear_log();
    pulse_start();
    wait_done("rerun_done");
    check("rerun_count", 32'(hs_instr.size()), 32'd4);
    if (hs_instr.size() >= 1) check("rerun_instr0", 32'(hs_instr[0]), 32'h1001);
    if (hs_instr.size() >= 4) check("rerun_instr3", 32'(hs_instr[3]), 32'h1004);

    // Single-entry program.
    end_addr = 5'd0; clear_log();
    pulse_start();
    wait_done("single_done");
    check("single_count", 32'(hs_instr.size()), 32'd1);
    check("single_pc", 32'(pc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
